// File: rtl/mtx_burst_ctrl_pkg.sv
// ============================================================================
// Module   : mtx_burst_ctrl_pkg
// Brief    : Shared state encodings and default generator dimensions for the
//            multitone TX burst controllers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mtx_burst_ctrl_pkg;

    // Encodings are shared with the other main_anc controllers; keep them stable.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int c_DEF_NSIG  = 5120;
    localparam int c_DEF_NSYMB = 256;

endpackage

`default_nettype wire

// File: rtl/mtx_symb_cnt.sv
// ============================================================================
// Module   : mtx_symb_cnt
// Brief    : Sample/symbol counter pair tracking the generator's free-running
//            phase counters; flags symbol and frame wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtx_symb_cnt
    import mtx_burst_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int NSYMB_WIDTH = 16,
    parameter int NSIG        = c_DEF_NSIG,
    parameter int NSYMB       = c_DEF_NSYMB
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_sample_last,
    output logic o_sym_wrap,
    output logic o_frm_wrap
);

    localparam logic [PHASE_WIDTH-1:0] c_S_LAST = PHASE_WIDTH'(NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] c_K_LAST = NSYMB_WIDTH'(NSYMB - 1);

    logic [PHASE_WIDTH-1:0] r_sample;
    logic [NSYMB_WIDTH-1:0] r_symb;

    assign o_sample_last = (r_sample == c_S_LAST);
    assign o_sym_wrap    = i_en & o_sample_last;
    assign o_frm_wrap    = o_sym_wrap & (r_symb == c_K_LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_sample <= '0;
            r_symb   <= '0;
        end else if (i_en) begin
            if (o_sample_last) begin
                r_sample <= '0;
                r_symb   <= (r_symb == c_K_LAST) ? '0 : r_symb + NSYMB_WIDTH'(1);
            end else begin
                r_sample <= r_sample + PHASE_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mtx_burst_ctrl.sv
// ============================================================================
// Module   : mtx_burst_ctrl
// Brief    : Sequences one multitone TX burst of the mtx_sig generator and
//            reports done/underflow/frame count. Optional inter-frame guard
//            gap enabled by defining MTX_BURST_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtx_burst_ctrl
    import mtx_burst_ctrl_pkg::*;
#(
    parameter int NSYMB_WIDTH = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int NSIG        = c_DEF_NSIG,
    parameter int NSYMB       = c_DEF_NSYMB,
    parameter int NFRM_WIDTH  = 16,
    parameter int GUARD_LEN   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NFRM_WIDTH-1:0] nframes,
    output logic                  gen_srst,
    output logic                  phase_tvalid,
    output logic                  phase_tlast,
    input  logic                  phase_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  underflow,
    output logic [NFRM_WIDTH-1:0] frame_cnt
);

    localparam int                c_GAP_W    = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GUARD_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NFRM_WIDTH-1:0] r_nframes;
    logic [NFRM_WIDTH-1:0] r_frame_cnt;
    logic                  r_abort_pend;
    logic                  r_underflow;
    logic [c_GAP_W-1:0]    r_gap_cnt;

    logic w_run;
    logic w_start_ok;
    logic w_abort;
    logic w_last_frame;
    logic w_sample_last;
    logic w_sym_wrap;
    logic w_frm_wrap;

    assign w_run        = (r_state == ST_RUN);
    assign w_start_ok   = start && (nframes != '0) && (r_state == ST_IDLE);
    // An abort arriving on the wrap cycle itself takes effect on that wrap.
    assign w_abort      = r_abort_pend | abort;
    assign w_last_frame = ((r_frame_cnt + NFRM_WIDTH'(1)) == r_nframes);

    mtx_symb_cnt #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .NSYMB_WIDTH (NSYMB_WIDTH),
        .NSIG        (NSIG),
        .NSYMB       (NSYMB)
    ) u_symb_cnt (
        .clk           (clk),
        .reset         (reset),
        .i_clr         (~w_run),
        .i_en          (w_run),
        .o_sample_last (w_sample_last),
        .o_sym_wrap    (w_sym_wrap),
        .o_frm_wrap    (w_frm_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_ARM;
            ST_ARM:  w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_frm_wrap && w_last_frame) begin
                    w_state_nxt = ST_DONE;
                end else if (w_sym_wrap && w_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (w_frm_wrap) begin
`ifdef MTX_BURST_GUARD_EN
                    w_state_nxt = ST_GAP;
`else
                    w_state_nxt = ST_RUN;
`endif
                end
            end
            ST_GAP: begin
                if (w_abort) begin
                    w_state_nxt = ST_DONE;
                end else if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_nframes    <= '0;
            r_frame_cnt  <= '0;
            r_abort_pend <= 1'b0;
            r_underflow  <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + c_GAP_W'(1) : '0;

            if (w_start_ok) begin
                r_nframes    <= nframes;
                r_frame_cnt  <= '0;
                r_underflow  <= 1'b0;
                r_abort_pend <= 1'b0;
            end else begin
                if (w_frm_wrap) begin
                    r_frame_cnt <= r_frame_cnt + NFRM_WIDTH'(1);
                end
                if (w_run && !phase_tready) begin
                    r_underflow <= 1'b1;
                end
                if (r_state == ST_DONE) begin
                    r_abort_pend <= 1'b0;
                end else if (abort && (r_state != ST_IDLE)) begin
                    r_abort_pend <= 1'b1;
                end
            end
        end
    end

    assign gen_srst     = ~w_run;
    assign phase_tvalid = w_run;
    assign phase_tlast  = w_run & w_sample_last;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign underflow    = r_underflow;
    assign frame_cnt    = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mtx_burst_ctrl.sv
// ============================================================================
// Module   : tb_mtx_burst_ctrl
// Brief    : Self-checking bench for mtx_burst_ctrl (NSIG=8, NSYMB=4, GUARD_LEN=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtx_burst_ctrl;

    localparam int NSIG  = 8;
    localparam int NSYMB = 4;
    localparam int F     = NSIG * NSYMB;
    localparam int GLEN  = 4;
`ifdef MTX_BURST_GUARD_EN
    localparam int G = GLEN;
`else
    localparam int G = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] nframes;
    logic        gen_srst;
    logic        phase_tvalid;
    logic        phase_tlast;
    logic        phase_tready;
    logic        busy;
    logic        done;
    logic        underflow;
    logic [15:0] frame_cnt;

    int   n_chk = 0;
    int   n_fail = 0;
    logic exp_uf_prev = 1'b0;
    int   exp_fc_prev = 0;

    mtx_burst_ctrl #(
        .NSYMB_WIDTH (16),
        .PHASE_WIDTH (24),
        .NSIG        (NSIG),
        .NSYMB       (NSYMB),
        .NFRM_WIDTH  (16),
        .GUARD_LEN   (GLEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .nframes      (nframes),
        .gen_srst     (gen_srst),
        .phase_tvalid (phase_tvalid),
        .phase_tlast  (phase_tlast),
        .phase_tready (phase_tready),
        .busy         (busy),
        .done         (done),
        .underflow    (underflow),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input int cyc, input bit e_busy, input bit e_srst, input bit e_valid,
                             input bit e_last, input bit e_done, input bit e_uf, input int e_fc);
        chk("busy",      cyc, 32'(busy),         32'(e_busy));
        chk("gen_srst",  cyc, 32'(gen_srst),     32'(e_srst));
        chk("tvalid",    cyc, 32'(phase_tvalid), 32'(e_valid));
        chk("tlast",     cyc, 32'(phase_tlast),  32'(e_last));
        chk("done",      cyc, 32'(done),         32'(e_done));
        chk("underflow", cyc, 32'(underflow),    32'(e_uf));
        chk("frame_cnt", cyc, 32'(frame_cnt),    32'(e_fc));
    endtask

    // Cycles from first RUN cycle until DONE, given abort at RUN offset oa (-1: none).
    function automatic int burst_len(input int n, input int oa);
        int tn, ta, slot, pos;
        tn = n * F + (n - 1) * G;
        if (oa < 0 || oa >= tn) return tn;
        slot = oa / (F + G);
        pos  = oa % (F + G);
        if (pos < F) ta = slot * (F + G) + (pos / NSIG + 1) * NSIG;
        else         ta = oa + 1;
        return (ta < tn) ? ta : tn;
    endfunction

    // Frames whose last sample lies before RUN offset o and inside the burst.
    function automatic int frames_done(input int n, input int t, input int o);
        int cnt = 0;
        for (int j = 0; j < n; j++) begin
            int e = j * (F + G) + F - 1;
            if (e < o && e < t) cnt++;
        end
        return cnt;
    endfunction

    // Cycle 0 pulses start; optional events at given relative cycles (-1 = none).
    task automatic run_burst(input int n, input int c_abort, input int c_drop,
                             input int c_bstart, input int c_reset);
        int  oa, t, o, pos;
        bit  drop_hit, v, l, d, b, uf;
        int  fc;
        oa = (c_abort < 0) ? -1 : ((c_abort < 2) ? 0 : c_abort - 2);
        t  = burst_len(n, oa);
        drop_hit = (c_drop >= 2) && ((c_drop - 2) < t) && (((c_drop - 2) % (F + G)) < F);
        for (int c = 0; c <= t + 3; c++) begin
            @(posedge clk);
            #1;
            start        = (c == 0) || (c == c_bstart);
            nframes      = (c == 0) ? 16'(n) : 16'($urandom_range(1, 3));
            abort        = (c == c_abort);
            phase_tready = (c != c_drop);
            reset        = (c == c_reset);
            @(negedge clk);
            if (c_reset >= 0 && c == c_reset + 1) begin
                check_all(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
                exp_uf_prev = 1'b0;
                exp_fc_prev = 0;
                return;
            end
            o   = c - 2;
            pos = (o >= 0) ? o % (F + G) : 0;
            v   = (c >= 2) && (o < t) && (pos < F);
            l   = v && ((pos % NSIG) == NSIG - 1);
            d   = (c >= 2) && (o == t);
            b   = (c >= 1) && (o <= t);
            uf  = (c == 0) ? exp_uf_prev : (drop_hit && c > c_drop);
            fc  = (c == 0) ? exp_fc_prev : frames_done(n, t, o);
            check_all(c, b, !v, v, l, d, uf, fc);
        end
        exp_uf_prev  = drop_hit;
        exp_fc_prev  = frames_done(n, t, t + 1);
        start        = 1'b0;
        abort        = 1'b0;
        phase_tready = 1'b1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        nframes      = 16'd0;
        phase_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all(-1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Plain two-frame burst.
        run_burst(2, -1, -1, -1, -1);
        // Abort shortly into a three-frame burst.
        run_burst(3, 7, -1, -1, -1);
        // tready dropped mid-run; following burst clears underflow.
        run_burst(2, -1, 20, -1, -1);
        run_burst(1, -1, -1, -1, -1);
        // Reset during symbol 2.
        run_burst(3, -1, -1, -1, 2 + 2 * NSIG + 3);

        // Start with nframes==0 is ignored.
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b1; nframes = 16'd0;
        @(negedge clk);
        check_all(-2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_uf_prev, exp_fc_prev);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_all(-2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_uf_prev, exp_fc_prev);

        // Start while busy is ignored.
        run_burst(1, -1, -1, 10, -1);
        // Abort coinciding with frame end; abort during ARM.
        run_burst(2, 2 + F - 1, -1, -1, -1);
        run_burst(2, 1, -1, -1, -1);

        for (int i = 0; i < 8; i++) begin
            int n, tn, ca, cd;
            n  = $urandom_range(1, 3);
            tn = n * F + (n - 1) * G;
            ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tn + 1)) : -1;
            cd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, tn + 1)) : -1;
            run_burst(n, ca, cd, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
